// File: rtl/apu_regbus_arbiter.sv
// Round-robin arbiter sharing the APU register bus ($4000-$401F) between N_REQ requesters.
// One operation at a time: IDLE accept -> OP (bus driven OP_CYCLES cycles) -> RSP pulse.
module apu_regbus_arbiter #(
  parameter int N_REQ     = 3,
  parameter int OP_CYCLES = 1
) (
  input  logic                 PHI0,
  input  logic                 RES,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_rnw,
  input  logic [5*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_rdata,
  input  logic [7:0]           D_in,
  output logic                 RnW,
  output logic [15:0]          A,
  output logic [7:0]           D_out,
  output logic                 D_oe,
  output logic                 bus_busy
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_rr_ptr;
  logic [3:0]         r_cnt;
  logic [N_REQ-1:0]   r_gnt_oh;
  logic               r_rnw;
  logic [15:0]        r_a;
  logic [7:0]         r_d_out;
  logic               r_d_oe;
  logic               r_busy;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [7:0]         r_rsp_rdata;

  logic [2*N_REQ-1:0] w_rot;
  logic               w_found;
  logic [N_REQ-1:0]   w_sel;
  logic [PW-1:0]      w_next_ptr;
  logic               w_sel_rnw;
  logic [4:0]         w_sel_reg;
  logic [7:0]         w_sel_wdata;
  logic               w_accept;

  // Rotate valids so the search starts at rr_ptr, then pick the first one and mux its request fields.
  always_comb begin
    int v_off;
    int v_idx;
    v_off       = 0;
    v_idx       = 0;
    w_found     = 1'b0;
    w_sel       = '0;
    w_sel_rnw   = 1'b1;
    w_sel_reg   = 5'd0;
    w_sel_wdata = 8'd0;
    w_next_ptr  = '0;
    w_rot       = {req_valid, req_valid} >> r_rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        v_off   = k;
      end else begin
        v_off   = v_off;
      end
    end
    v_idx = int'(r_rr_ptr) + v_off;
    if (v_idx >= N_REQ) begin
      v_idx = v_idx - N_REQ;
    end else begin
      v_idx = v_idx;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (w_found && (k == v_idx)) begin
        w_sel[k]    = 1'b1;
        w_sel_rnw   = req_rnw[k];
        w_sel_reg   = req_reg[5*k +: 5];
        w_sel_wdata = req_wdata[8*k +: 8];
      end else begin
        w_sel[k]    = 1'b0;
      end
    end
    // Explicit wrap keeps the pointer inside 0..N_REQ-1.
    if (v_idx == N_REQ - 1) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = PW'(v_idx + 1);
    end
  end

  // Ready is only offered while idle; accept happens on the edge where it meets a valid.
  always_comb begin
    if (r_state == S_IDLE) begin
      req_ready = w_sel;
    end else begin
      req_ready = '0;
    end
    w_accept = (r_state == S_IDLE) && w_found;
  end

  // Arbiter FSM with registered bus and response outputs.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= 4'd0;
      r_gnt_oh    <= '0;
      r_rnw       <= 1'b1;
      r_a         <= 16'h0000;
      r_d_out     <= 8'h00;
      r_d_oe      <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= '0;
          if (w_accept) begin
            r_state  <= S_OP;
            r_rr_ptr <= w_next_ptr;
            r_cnt    <= 4'(OP_CYCLES - 1);
            r_gnt_oh <= w_sel;
            r_rnw    <= w_sel_rnw;
            r_a      <= 16'h4000 | {11'd0, w_sel_reg};
            r_d_out  <= w_sel_wdata;
            r_d_oe   <= ~w_sel_rnw;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_OP: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RSP;
            r_rsp_valid <= r_gnt_oh;
            r_rsp_rdata <= r_rnw ? D_in : 8'h00;
            r_rnw       <= 1'b1;
            r_a         <= 16'h0000;
            r_d_out     <= 8'h00;
            r_d_oe      <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_cnt       <= r_cnt - 4'd1;
          end
        end
        S_RSP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= '0;
          r_rnw       <= 1'b1;
          r_a         <= 16'h0000;
          r_d_out     <= 8'h00;
          r_d_oe      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign RnW       = r_rnw;
  assign A         = r_a;
  assign D_out     = r_d_out;
  assign D_oe      = r_d_oe;
  assign bus_busy  = r_busy;

endmodule

// File: tb/tb_apu_regbus_arbiter.sv
// Directed bench for apu_regbus_arbiter: one instance with OP_CYCLES=1, one with OP_CYCLES=4.
module tb_apu_regbus_arbiter;

  logic        clk;
  logic        res1, res4;
  logic [2:0]  v1, v4;
  logic [2:0]  rnw;
  logic [14:0] regs;
  logic [23:0] wdata;
  logic [7:0]  din;

  logic [2:0]  rdy1, rsp1, rdy4, rsp4;
  logic [7:0]  rdata1, rdata4, dout1, dout4;
  logic        rnwo1, rnwo4, doe1, doe4, busy1, busy4;
  logic [15:0] a1, a4;

  int n_cmp;
  int n_bad;

  apu_regbus_arbiter #(.N_REQ(3), .OP_CYCLES(1)) dut1 (
    .PHI0(clk), .RES(res1), .req_valid(v1), .req_rnw(rnw), .req_reg(regs),
    .req_wdata(wdata), .req_ready(rdy1), .rsp_valid(rsp1), .rsp_rdata(rdata1),
    .D_in(din), .RnW(rnwo1), .A(a1), .D_out(dout1), .D_oe(doe1), .bus_busy(busy1)
  );

  apu_regbus_arbiter #(.N_REQ(3), .OP_CYCLES(4)) dut4 (
    .PHI0(clk), .RES(res4), .req_valid(v4), .req_rnw(rnw), .req_reg(regs),
    .req_wdata(wdata), .req_ready(rdy4), .rsp_valid(rsp4), .rsp_rdata(rdata4),
    .D_in(din), .RnW(rnwo4), .A(a4), .D_out(dout4), .D_oe(doe4), .bus_busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_ops;
    int last;
    n_cmp = 0;
    n_bad = 0;
    res1 = 1'b1; res4 = 1'b1;
    v1 = 3'b000; v4 = 3'b000;
    rnw = 3'b111; regs = 15'd0; wdata = 24'd0; din = 8'd0;
    step();
    step();
    res1 = 1'b0; res4 = 1'b0;

    // Reset state
    chk("rst_a",      {16'd0, a1},     32'h0000);
    chk("rst_rnw",    {31'd0, rnwo1},  32'd1);
    chk("rst_doe",    {31'd0, doe1},   32'd0);
    chk("rst_dout",   {24'd0, dout1},  32'd0);
    chk("rst_busy",   {31'd0, busy1},  32'd0);
    chk("rst_rsp",    {29'd0, rsp1},   32'd0);
    chk("rst_rdata",  {24'd0, rdata1}, 32'd0);
    chk("rst_ready",  {29'd0, rdy1},   32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_hold", {12'd0, a1, rnwo1, doe1, rdy1}, {12'd0, 16'h0000, 1'b1, 1'b0, 3'b000});
      step();
    end

    // Req0 write reg 0x15 data 0x0F
    v1 = 3'b001; rnw = 3'b110; regs = 15'h0015; wdata = 24'h00000F;
    #1;
    chk("wr_ready", {29'd0, rdy1}, 32'd1);
    step();
    v1 = 3'b000; wdata = 24'h0000AA;
    chk("wr_a",     {16'd0, a1},    32'h4015);
    chk("wr_rnw",   {31'd0, rnwo1}, 32'd0);
    chk("wr_doe",   {31'd0, doe1},  32'd1);
    chk("wr_dout",  {24'd0, dout1}, 32'h0F);
    chk("wr_busy",  {31'd0, busy1}, 32'd1);
    chk("wr_rdy_op",{29'd0, rdy1},  32'd0);
    step();
    chk("wr_rsp",   {29'd0, rsp1},   32'd1);
    chk("wr_rdata", {24'd0, rdata1}, 32'h00);
    chk("wr_idle",  {15'd0, a1, doe1}, 32'd0);
    step();
    chk("wr_rsp_end", {29'd0, rsp1}, 32'd0);

    // Req1 read reg 0x15, D_in=0x41 during OP
    v1 = 3'b010; rnw = 3'b111; regs = 15'h0015 << 5;
    #1;
    chk("rd_ready", {29'd0, rdy1}, 32'd2);
    step();
    v1 = 3'b000; din = 8'h41;
    chk("rd_a",    {16'd0, a1},    32'h4015);
    chk("rd_rnw",  {31'd0, rnwo1}, 32'd1);
    chk("rd_doe",  {31'd0, doe1},  32'd0);
    step();
    din = 8'h00;
    chk("rd_rsp",   {29'd0, rsp1},   32'd2);
    chk("rd_rdata", {24'd0, rdata1}, 32'h41);
    step();
    chk("rd_hold",  {24'd0, rdata1}, 32'h41);

    // All three valid: grant order 0,1,2,... accepts 3 cycles apart
    res1 = 1'b1;
    step();
    res1 = 1'b0;
    v1 = 3'b111;
    n_ops = 0;
    last = 0;
    #1;
    for (int cyc = 0; cyc < 60 && n_ops < 9; cyc++) begin
      if (rdy1 != 3'b000) begin
        chk("rr_grant", {29'd0, rdy1}, 32'd1 << (n_ops % 3));
        if (n_ops > 0) begin
          chk("rr_spacing", cyc - last, 32'd3);
        end else begin
          last = cyc;
        end
        last = cyc;
        n_ops++;
      end else begin
        last = last;
      end
      step();
    end
    chk("rr_count", n_ops, 32'd9);
    v1 = 3'b000;

    // OP_CYCLES=4: req2 write reg 0x00 data 0xBF
    v4 = 3'b100; rnw = 3'b011; regs = 15'd0; wdata = 24'hBF0000;
    #1;
    chk("op4_ready", {29'd0, rdy4}, 32'd4);
    step();
    v4 = 3'b000; regs = 15'h7FFF; wdata = 24'h550000; rnw = 3'b111;
    for (int i = 0; i < 4; i++) begin
      chk("op4_bus", {a4, dout4, rnwo4, doe4, busy4, rsp4, 2'b00},
                     {16'h4000, 8'hBF, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00});
      step();
    end
    chk("op4_rsp",   {29'd0, rsp4},   32'd4);
    chk("op4_rdata", {24'd0, rdata4}, 32'h00);
    chk("op4_idle",  {15'd0, a4, busy4}, 32'd0);
    step();
    chk("op4_rsp_end", {29'd0, rsp4}, 32'd0);

    // Reset during second OP cycle aborts the op and rewinds the pointer
    v4 = 3'b001; rnw = 3'b111; regs = 15'h0003;
    #1;
    chk("abort_ready", {29'd0, rdy4}, 32'd1);
    step();
    v4 = 3'b000;
    chk("abort_op1", {31'd0, busy4}, 32'd1);
    step();
    res4 = 1'b1;
    chk("abort_op2", {31'd0, busy4}, 32'd1);
    step();
    res4 = 1'b0;
    chk("abort_idle", {a4, rnwo4, doe4, busy4, rsp4, 10'd0},
                      {16'h0000, 1'b1, 1'b0, 1'b0, 3'b000, 10'd0});
    for (int i = 0; i < 6; i++) begin
      chk("abort_norsp", {29'd0, rsp4}, 32'd0);
      step();
    end
    v4 = 3'b111;
    #1;
    chk("abort_grant0", {29'd0, rdy4}, 32'd1);
    v4 = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
